line_vram_builder: RTL and testbench

LINE_VRAM_BUILDER -- requirements
Module: line_vram_builder

---
 rtl/snake_pkg.sv | 46 ++++
 rtl/line_vram_builder_if.sv | 40 ++++
 rtl/line_vram_builder.sv | 130 +++++++++++++
 tb/tb_line_vram_builder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// ============================================================
// snake_pkg: grid geometry, cell/mode codes, line-builder FSM
// Revision: 1.0
// ============================================================
`default_nettype none

package snake_pkg;

  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int MAX_NODES = 16;
  localparam int LINE_W    = 2 * GRID_W;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_WALL  = 2'b01,
    CELL_SNAKE = 2'b10,
    CELL_APPLE = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_PLAY = 2'b01,
    MODE_OVER = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLEAR   = 2'b01,
    ST_SCAN    = 2'b10,
    ST_PUBLISH = 2'b11
  } state_t;

  // Bit offset of cell x's pair inside a packed line
  function automatic logic [6:0] cell_lsb(input logic [5:0] x);
    return {x, 1'b0};
  endfunction

  function automatic logic on_grid(input logic [5:0] x, input logic [5:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_vram_builder_if.sv
// ============================================================
// line_vram_builder_if: line request, game state and node bus
// Revision: 1.0
// ============================================================
`default_nettype none

interface line_vram_builder_if
  import snake_pkg::*;
();

  logic [5:0]                     y_pos;
  logic                           line_req;
  logic [1:0]                     mode;
  logic [$clog2(MAX_NODES)-1:0]   cubenum;
  logic [5:0]                     head_x;
  logic [5:0]                     head_y;
  logic [5:0]                     apple_x;
  logic [5:0]                     apple_y;
  logic [$clog2(MAX_NODES)-1:0]   node;
  logic [5:0]                     node_cube_x;
  logic [5:0]                     node_cube_y;
  logic [LINE_W-1:0]              Line_VRAM;
  logic                           line_busy;
  logic                           line_done;

  modport master (
    output y_pos, line_req, mode, cubenum, head_x, head_y, apple_x, apple_y,
    output node_cube_x, node_cube_y,
    input  node, Line_VRAM, line_busy, line_done
  );

  modport slave (
    input  y_pos, line_req, mode, cubenum, head_x, head_y, apple_x, apple_y,
    input  node_cube_x, node_cube_y,
    output node, Line_VRAM, line_busy, line_done
  );

endinterface

`default_nettype wire

// File: rtl/line_vram_builder.sv
// ============================================================
// line_vram_builder: renders one grid row into a double-buffered line
// Revision: 1.0
// ============================================================
`default_nettype none

module line_vram_builder
  import snake_pkg::*;
(
  input  logic              clk_50MHz,
  input  logic              rst,
  line_vram_builder_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        row;
  mode_t             mode_l;
  logic [3:0]        len;
  logic [5:0]        head_x_l;
  logic [5:0]        head_y_l;
  logic [5:0]        apple_x_l;
  logic [5:0]        apple_y_l;
  logic [3:0]        cnt;
  logic [LINE_W-1:0] work;
  logic [LINE_W-1:0] vram;
  logic [LINE_W-1:0] clear_line;
  logic [3:0]        node_idx;
  logic              busy;
  logic              done;

  assign bus.node      = node_idx;
  assign bus.Line_VRAM = vram;
  assign bus.line_busy = busy;
  assign bus.line_done = done;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SCAN spends L cycles issuing node indices plus one to absorb the last read
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    node_idx  = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.line_req) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (cnt != len) node_idx = cnt;
        else            state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Background row: walls, then apple, then head (later writes win)
  always_comb begin
    clear_line = '0;
    if (int'(row) < GRID_H) begin
      for (int x = 0; x < GRID_W; x++) begin
        if (row == 6'd0 || row == 6'(GRID_H - 1) || x == 0 || x == GRID_W - 1)
          clear_line[2*x +: 2] = CELL_WALL;
      end
      if (mode_l != MODE_IDLE) begin
        if (on_grid(apple_x_l, apple_y_l) && apple_y_l == row)
          clear_line[cell_lsb(apple_x_l) +: 2] = CELL_APPLE;
        if (on_grid(head_x_l, head_y_l) && head_y_l == row)
          clear_line[cell_lsb(head_x_l) +: 2] = CELL_SNAKE;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      row       <= '0;
      mode_l    <= MODE_IDLE;
      len       <= '0;
      head_x_l  <= '0;
      head_y_l  <= '0;
      apple_x_l <= '0;
      apple_y_l <= '0;
      cnt       <= '0;
      work      <= '0;
      vram      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.line_req) begin
            row       <= bus.y_pos;
            mode_l    <= mode_t'(bus.mode);
            len       <= bus.cubenum;
            head_x_l  <= bus.head_x;
            head_y_l  <= bus.head_y;
            apple_x_l <= bus.apple_x;
            apple_y_l <= bus.apple_y;
          end
        end
        ST_CLEAR: begin
          work <= clear_line;
          cnt  <= '0;
        end
        ST_SCAN: begin
          if (cnt != len) cnt <= cnt + 4'd1;
          // node_cube_* now reflects the index issued on the previous cycle
          if (cnt != 4'd0 && mode_l != MODE_IDLE &&
              on_grid(bus.node_cube_x, bus.node_cube_y) && bus.node_cube_y == row)
            work[cell_lsb(bus.node_cube_x) +: 2] <= CELL_SNAKE;
        end
        ST_PUBLISH: vram <= work;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_vram_builder.sv
// ============================================================
// tb_line_vram_builder: directed checks of line_vram_builder
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_line_vram_builder;

  logic clk_50MHz = 1'b0;
  logic rst;

  line_vram_builder_if bus();

  line_vram_builder dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Body node memory: one-cycle read latency
  logic [5:0] nx [0:15];
  logic [5:0] ny [0:15];
  always @(posedge clk_50MHz) begin
    bus.node_cube_x <= nx[bus.node];
    bus.node_cube_y <= ny[bus.node];
  end

  int   checks = 0;
  int   errors = 0;
  int   first_done;
  int   ndone;
  int   node_log [0:31];
  logic busy_log [0:31];
  logic [79:0] exp_line;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] with_cell(input logic [79:0] l, input int x, input logic [1:0] c);
    logic [79:0] r;
    r = l;
    r[2*x +: 2] = c;
    return r;
  endfunction

  task automatic start_line(input logic [5:0] y, input logic [1:0] m, input logic [3:0] l,
                            input logic [5:0] ax, input logic [5:0] ay,
                            input logic [5:0] hx, input logic [5:0] hy);
    @(posedge clk_50MHz);
    #1;
    bus.y_pos    = y;
    bus.mode     = m;
    bus.cubenum  = l;
    bus.apple_x  = ax;
    bus.apple_y  = ay;
    bus.head_x   = hx;
    bus.head_y   = hy;
    bus.line_req = 1'b1;
    @(posedge clk_50MHz);
    #1;
    bus.line_req = 1'b0;
  endtask

  // Observe cycles 1..max_c after the request; optionally disturb the build
  task automatic run(input int max_c, input int inject_at, input int rst_at);
    first_done = -1;
    ndone      = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk_50MHz);
      if (c < 32) begin
        node_log[c] = int'(bus.node);
        busy_log[c] = bus.line_busy;
      end
      if (bus.line_done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (inject_at >= 0 && c == 1) begin
        bus.mode    = 2'b00;
        bus.head_x  = 6'd30;
        bus.cubenum = 4'd9;
      end
      if (inject_at >= 0 && c == inject_at) begin
        bus.line_req = 1'b1;
        bus.y_pos    = 6'd0;
      end
      if (inject_at >= 0 && c == inject_at + 1) bus.line_req = 1'b0;
      if (c == rst_at)     rst = 1'b1;
      if (c == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.y_pos    = '0;
    bus.line_req = 1'b0;
    bus.mode     = '0;
    bus.cubenum  = '0;
    bus.head_x   = '0;
    bus.head_y   = '0;
    bus.apple_x  = '0;
    bus.apple_y  = '0;
    for (int i = 0; i < 16; i++) begin
      nx[i] = 6'd63;
      ny[i] = 6'd63;
    end
    repeat (3) @(posedge clk_50MHz);
    #1;
    rst = 1'b0;
    @(negedge clk_50MHz);
    check("rst_vram", bus.Line_VRAM, 80'd0);
    check("rst_busy", 80'(bus.line_busy), 80'd0);
    check("rst_done", 80'(bus.line_done), 80'd0);
    check("rst_node", 80'(bus.node), 80'd0);

    // Play row with apple and head, no body nodes
    start_line(6'd5, 2'b01, 4'd0, 6'd7, 6'd5, 6'd20, 6'd5);
    run(7, -1, -1);
    check("t1_latency", 80'(first_done), 80'd3);
    check("t1_ndone", 80'(ndone), 80'd1);
    check("t1_busy_c1", 80'(busy_log[1]), 80'd1);
    check("t1_busy_end", 80'(bus.line_busy), 80'd0);
    exp_line = with_cell(80'd0, 0, 2'b01);
    exp_line = with_cell(exp_line, 39, 2'b01);
    exp_line = with_cell(exp_line, 7, 2'b11);
    exp_line = with_cell(exp_line, 20, 2'b10);
    check("t1_line", bus.Line_VRAM, exp_line);

    // Top wall row in idle mode: apple, head and nodes suppressed
    for (int i = 0; i < 3; i++) begin
      nx[i] = 6'(10 + i);
      ny[i] = 6'd0;
    end
    start_line(6'd0, 2'b00, 4'd3, 6'd5, 6'd0, 6'd6, 6'd0);
    run(10, -1, -1);
    check("t2_latency", 80'(first_done), 80'd6);
    exp_line = '0;
    for (int x = 0; x < 40; x++) exp_line = with_cell(exp_line, x, 2'b01);
    check("t2_line", bus.Line_VRAM, exp_line);

    // Row beyond the grid publishes all zero
    start_line(6'd30, 2'b01, 4'd0, 6'd3, 6'd30, 6'd4, 6'd30);
    run(7, -1, -1);
    check("t3_latency", 80'(first_done), 80'd3);
    check("t3_line", bus.Line_VRAM, 80'd0);

    // Full 15-node body along row 10
    for (int i = 0; i < 15; i++) begin
      nx[i] = 6'(i + 1);
      ny[i] = 6'd10;
    end
    start_line(6'd10, 2'b01, 4'd15, 6'd30, 6'd2, 6'd35, 6'd11);
    run(22, -1, -1);
    check("t4_latency", 80'(first_done), 80'd18);
    check("t4_ndone", 80'(ndone), 80'd1);
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("t4_node_c%0d", c), 80'(node_log[c]),
            (c >= 2 && c <= 16) ? 80'(c - 2) : 80'd0);
    end
    exp_line = with_cell(80'd0, 39, 2'b01);
    for (int x = 1; x <= 15; x++) exp_line = with_cell(exp_line, x, 2'b10);
    exp_line = with_cell(exp_line, 0, 2'b01);
    check("t4_line", bus.Line_VRAM, exp_line);

    // Node overrides apple; off-grid head is dropped
    nx[0] = 6'd12;
    ny[0] = 6'd8;
    start_line(6'd8, 2'b01, 4'd1, 6'd12, 6'd8, 6'd45, 6'd8);
    run(8, -1, -1);
    check("t5_latency", 80'(first_done), 80'd4);
    exp_line = with_cell(80'd0, 0, 2'b01);
    exp_line = with_cell(exp_line, 39, 2'b01);
    exp_line = with_cell(exp_line, 12, 2'b10);
    check("t5_line", bus.Line_VRAM, exp_line);

    // Request while busy is dropped; mid-build input changes are ignored
    start_line(6'd5, 2'b01, 4'd0, 6'd7, 6'd5, 6'd22, 6'd5);
    run(12, 2, -1);
    check("t6_latency", 80'(first_done), 80'd3);
    check("t6_ndone", 80'(ndone), 80'd1);
    check("t6_busy_end", 80'(bus.line_busy), 80'd0);
    exp_line = with_cell(80'd0, 0, 2'b01);
    exp_line = with_cell(exp_line, 39, 2'b01);
    exp_line = with_cell(exp_line, 7, 2'b11);
    exp_line = with_cell(exp_line, 22, 2'b10);
    check("t6_line", bus.Line_VRAM, exp_line);

    // Reset in cycle 2 aborts the build
    start_line(6'd0, 2'b00, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
    run(7, -1, 2);
    check("t7_ndone", 80'(ndone), 80'd0);
    check("t7_vram", bus.Line_VRAM, 80'd0);
    check("t7_busy", 80'(bus.line_busy), 80'd0);
    start_line(6'd5, 2'b01, 4'd0, 6'd7, 6'd5, 6'd20, 6'd5);
    run(7, -1, -1);
    check("t7_relatency", 80'(first_done), 80'd3);
    exp_line = with_cell(80'd0, 0, 2'b01);
    exp_line = with_cell(exp_line, 39, 2'b01);
    exp_line = with_cell(exp_line, 7, 2'b11);
    exp_line = with_cell(exp_line, 20, 2'b10);
    check("t7_reline", bus.Line_VRAM, exp_line);

    // Request coincident with reset is not accepted
    @(posedge clk_50MHz);
    #1;
    rst          = 1'b1;
    bus.line_req = 1'b1;
    bus.y_pos    = 6'd5;
    @(posedge clk_50MHz);
    #1;
    rst          = 1'b0;
    bus.line_req = 1'b0;
    @(negedge clk_50MHz);
    check("t8_busy", 80'(bus.line_busy), 80'd0);
    check("t8_vram", bus.Line_VRAM, 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
